// File: rtl/alarm_watch_pkg.sv
// Shared types and constants for the alarm watch core: FSM state encoding,
// packed BCD HH:MM time, digit limits and the load-value validity check.
// Build option: define ALARM_WATCH_SNOOZE_EN to include the SNOOZE state.
package alarm_watch_pkg;

`ifdef ALARM_WATCH_SNOOZE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_t;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RING = 1'b1
    } alarm_state_t;
`endif

    typedef struct packed {
        logic [3:0] hr_tens;
        logic [3:0] hr_ones;
        logic [3:0] min_tens;
        logic [3:0] min_ones;
    } bcd_time_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] TENS_MAX     = 4'd5;
    localparam int         HOURS_MAX    = 23;
    localparam logic [3:0] HR_TENS_MAX  = 4'(HOURS_MAX / 10);
    localparam logic [3:0] HR_ONES_LAST = 4'(HOURS_MAX % 10);

    // A load value is accepted only if it is a legal 24-hour BCD time.
    function automatic logic bcd_time_valid(input bcd_time_t t);
        int hours;
        hours = 10 * int'(t.hr_tens) + int'(t.hr_ones);
        return (t.hr_tens <= DIGIT_MAX) && (t.hr_ones <= DIGIT_MAX) &&
               (t.min_tens <= TENS_MAX) && (t.min_ones <= DIGIT_MAX) &&
               (hours <= HOURS_MAX);
    endfunction

endpackage

// File: rtl/alarm_watch_core_bcd_digit_cnt.sv
// One BCD digit of the time-of-day chain: counts 0..MAX on carry-in,
// wraps early when 'wrap' is set (used for 23 -> 00 on the hour pair),
// and takes a synchronous load with priority over counting.
// q_nxt exposes the value the digit will hold after this edge.
module bcd_digit_cnt #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       cin,
    input  logic       wrap,
    output logic [3:0] q,
    output logic [3:0] q_nxt,
    output logic       cout
);

    logic at_top;

    assign at_top = (q == MAX) || wrap;
    assign cout   = cin && at_top;

    // Next digit value: load wins, otherwise increment or roll over on carry-in.
    always_comb begin
        q_nxt = q;
        if (load) begin
            q_nxt = load_val;
        end else if (cin) begin
            q_nxt = at_top ? 4'd0 : q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else begin
            q <= q_nxt;
        end
    end

endmodule

// File: rtl/alarm_watch_core.sv
// Alarm watch core: 1 Hz prescaler, cascaded BCD HH:MM:SS clock, validated
// time/alarm loads and an alarm FSM (IDLE / RING, plus SNOOZE when the
// ALARM_WATCH_SNOOZE_EN macro is defined; otherwise the snooze input is ignored).
module alarm_watch_core
    import alarm_watch_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_load,
    input  logic [15:0] time_in,
    input  logic        alarm_load,
    input  logic [15:0] alarm_in,
    input  logic        alarm_en,
    input  logic        stop,
    input  logic        snooze,
    output logic [15:0] time_out,
    output logic [7:0]  sec_out,
    output logic        sec_tick,
    output logic        alarm_ring,
    output logic        load_err
);

    localparam int              PRE_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam int              RING_W    = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

    bcd_time_t        tin;
    bcd_time_t        alarm_reg;
    logic             time_ok;
    logic             alarm_ok;
    logic [PRE_W-1:0] presc;
    logic [RING_W-1:0] ring_cnt;
    alarm_state_t     state;
    alarm_state_t     state_nxt;
    logic             hit;

    logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
    logic [3:0] sec_ones_nxt, sec_tens_nxt, min_ones_nxt, min_tens_nxt, hr_ones_nxt, hr_tens_nxt;
    logic       c_s1, c_s10, c_m1, c_m10, c_h1, hr_carry_unused;
    logic       hr_wrap;

    assign tin      = bcd_time_t'(time_in);
    assign time_ok  = time_load && bcd_time_valid(tin);
    assign alarm_ok = alarm_load && bcd_time_valid(bcd_time_t'(alarm_in));
    assign sec_tick = (presc == PRE_LAST) && !rst;
    assign hr_wrap  = ({hr_tens, hr_ones} == {HR_TENS_MAX, HR_ONES_LAST});

    assign time_out = {hr_tens, hr_ones, min_tens, min_ones};
    assign sec_out  = {sec_tens, sec_ones};

    // Prescaler: free-running modulo CLK_HZ, restarted by an accepted time load.
    always_ff @(posedge clk) begin
        if (rst || time_ok || presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_W'(1);
        end
    end

    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(4'd0), .cin(sec_tick), .wrap(1'b0),
        .q(sec_ones), .q_nxt(sec_ones_nxt), .cout(c_s1));
    bcd_digit_cnt #(.MAX(TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(4'd0), .cin(c_s1), .wrap(1'b0),
        .q(sec_tens), .q_nxt(sec_tens_nxt), .cout(c_s10));
    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(tin.min_ones), .cin(c_s10), .wrap(1'b0),
        .q(min_ones), .q_nxt(min_ones_nxt), .cout(c_m1));
    bcd_digit_cnt #(.MAX(TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(tin.min_tens), .cin(c_m1), .wrap(1'b0),
        .q(min_tens), .q_nxt(min_tens_nxt), .cout(c_m10));
    bcd_digit_cnt #(.MAX(DIGIT_MAX)) u_hr_ones (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(tin.hr_ones), .cin(c_m10), .wrap(hr_wrap),
        .q(hr_ones), .q_nxt(hr_ones_nxt), .cout(c_h1));
    bcd_digit_cnt #(.MAX(HR_TENS_MAX)) u_hr_tens (
        .clk(clk), .rst(rst), .load(time_ok), .load_val(tin.hr_tens), .cin(c_h1), .wrap(hr_wrap),
        .q(hr_tens), .q_nxt(hr_tens_nxt), .cout(hr_carry_unused));

    // Trigger only when a second tick (not a load) rolls the clock onto HH:MM:00 == alarm.
    assign hit = alarm_en && sec_tick && !time_ok &&
                 ({sec_tens_nxt, sec_ones_nxt} == 8'h00) &&
                 ({hr_tens_nxt, hr_ones_nxt, min_tens_nxt, min_ones_nxt} == alarm_reg);

    // Alarm register and rejected-load flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_reg <= '0;
            load_err  <= 1'b0;
        end else begin
            if (alarm_ok) begin
                alarm_reg <= bcd_time_t'(alarm_in);
            end
            load_err <= (time_load && !time_ok) || (alarm_load && !alarm_ok);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef ALARM_WATCH_SNOOZE_EN
    localparam int               SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int               SNZ_W     = (SNZ_TICKS > 1) ? $clog2(SNZ_TICKS) : 1;
    localparam logic [SNZ_W-1:0] SNZ_LAST  = SNZ_W'(SNZ_TICKS - 1);
    logic [SNZ_W-1:0] snz_cnt;

    // Snooze counter: counts seconds spent in SNOOZE, cleared outside it.
    always_ff @(posedge clk) begin
        if (rst || state != ST_SNOOZE || state_nxt != ST_SNOOZE) begin
            snz_cnt <= '0;
        end else if (sec_tick) begin
            snz_cnt <= snz_cnt + SNZ_W'(1);
        end
    end
`else
    localparam int snooze_ticks_unused = SNOOZE_MIN * 60;
    logic snooze_unused;
    assign snooze_unused = snooze;
`endif

    // FSM next state; stop beats snooze, and an accepted alarm load forces IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (hit) state_nxt = ST_RING;
            end
            ST_RING: begin
                if (stop || !alarm_en) begin
                    state_nxt = ST_IDLE;
`ifdef ALARM_WATCH_SNOOZE_EN
                end else if (snooze) begin
                    state_nxt = ST_SNOOZE;
`endif
                end else if (sec_tick && ring_cnt == RING_LAST) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef ALARM_WATCH_SNOOZE_EN
            ST_SNOOZE: begin
                if (stop || !alarm_en) begin
                    state_nxt = ST_IDLE;
                end else if (sec_tick && snz_cnt == SNZ_LAST) begin
                    state_nxt = ST_RING;
                end
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
        if (alarm_ok) state_nxt = ST_IDLE;
    end

    // Ring counter: counts seconds spent in RING, restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RING || state_nxt != ST_RING) begin
            ring_cnt <= '0;
        end else if (sec_tick) begin
            ring_cnt <= ring_cnt + RING_W'(1);
        end
    end

    // FSM outputs.
    always_comb begin
        alarm_ring = (state == ST_RING);
    end

endmodule
